// File: rtl/sha_cmd_sequencer_if.sv
// ---------------------------------------------------------------------------
// sha_cmd_sequencer_if
// Bundle of the host-side and core-side signals of the SHA-256 command
// sequencer.
//   START   host -> seq   begin a message
//   NBLK    host -> seq   number of 512-bit blocks in the message
//   FINAL_M host -> seq   last block stores its result into the message buffer
//   RDY     core -> seq   core command-complete flag
//   CMD     seq  -> core  command code (0/10/20/30/40)
//   H_SEL   seq  -> core  H source: 0 = IV ROM, 1 = running hash
//   BLK_IDX seq  -> core  message-block buffer index
//   BUSY    seq  -> host  message in progress
//   DONE    seq  -> host  one-cycle completion pulse
//   ERR     seq  -> host  sticky timeout flag
// Modports: master = the sequencer itself, slave = host/core environment.
// ---------------------------------------------------------------------------
interface sha_cmd_sequencer_if #(
  parameter int MAX_BLK = 4
);
  localparam int BW = $clog2(MAX_BLK + 1);

  logic          START;
  logic [BW-1:0] NBLK;
  logic          FINAL_M;
  logic          RDY;
  logic [7:0]    CMD;
  logic          H_SEL;
  logic [BW-1:0] BLK_IDX;
  logic          BUSY;
  logic          DONE;
  logic          ERR;

  modport master (
    input  START, NBLK, FINAL_M, RDY,
    output CMD, H_SEL, BLK_IDX, BUSY, DONE, ERR
  );

  modport slave (
    output START, NBLK, FINAL_M, RDY,
    input  CMD, H_SEL, BLK_IDX, BUSY, DONE, ERR
  );
endinterface

// File: rtl/sha_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// sha_cmd_sequencer
// Steps the SHA-256 window/compressor core through LOAD_H, HASH and SUM_STORE
// for every block of a multi-block message, selecting the H source and the
// message-block index, and flagging completion or a hung core.
// Ports:
//   CLK    clock, all logic on posedge
//   RST_N  synchronous active-low reset
//   bus    sha_cmd_sequencer_if.master (START/NBLK/FINAL_M/RDY in,
//          CMD/H_SEL/BLK_IDX/BUSY/DONE/ERR out, all outputs registered)
// ---------------------------------------------------------------------------
module sha_cmd_sequencer #(
  parameter int MAX_BLK     = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  sha_cmd_sequencer_if.master    bus
);

  localparam int BW = $clog2(MAX_BLK + 1);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [7:0]    CMD_IDLE    = 8'd0;
  localparam logic [7:0]    CMD_LOAD_H  = 8'd10;
  localparam logic [7:0]    CMD_HASH    = 8'd20;
  localparam logic [7:0]    CMD_SUM_H   = 8'd30;
  localparam logic [7:0]    CMD_SUM_M   = 8'd40;
  localparam logic [BW-1:0] BLK_ZERO    = {BW{1'b0}};
  localparam logic [BW-1:0] BLK_ONE     = BW'(1);
  localparam logic [BW-1:0] BLK_MAX     = BW'(MAX_BLK);
  localparam logic [CW-1:0] CNT_ZERO    = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  // Counter value at which the wait that is in progress has lasted TIMEOUT_CYC cycles.
  localparam logic [CW-1:0] CNT_LAST    = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_RDY, S_RELEASE, S_WAIT_CLR, S_DONE, S_ERR
  } state_t;

  typedef enum logic [1:0] {
    STEP_LOAD_H, STEP_HASH, STEP_SUM
  } step_t;

  // Command code for a step; the SUM flavour depends on the block position.
  function automatic logic [7:0] step_code(input step_t step, input logic last_blk,
                                           input logic final_m);
    logic [7:0] code;
    case (step)
      STEP_LOAD_H: code = CMD_LOAD_H;
      STEP_HASH:   code = CMD_HASH;
      STEP_SUM:    code = (last_blk && final_m) ? CMD_SUM_M : CMD_SUM_H;
      default:     code = CMD_IDLE;
    endcase
    return code;
  endfunction

  state_t        state_r,   state_s;
  step_t         step_r,    step_s;
  logic [BW-1:0] nblk_r,    nblk_s;
  logic          final_m_r, final_m_s;
  logic [BW-1:0] blk_idx_r, blk_idx_s;
  logic [CW-1:0] cnt_r,     cnt_s;
  logic [7:0]    cmd_r,     cmd_s;
  logic          h_sel_r,   h_sel_s;
  logic          busy_r,    busy_s;
  logic          done_r,    done_s;
  logic          err_r,     err_s;

  logic          start_ok_s;
  logic          last_blk_s;

  // START is only meaningful with a block count in 1..MAX_BLK.
  assign start_ok_s = bus.START && (bus.NBLK != BLK_ZERO) && (bus.NBLK <= BLK_MAX);
  assign last_blk_s = (blk_idx_r == (nblk_r - BLK_ONE));

  // Next-state and next-output logic of the command sequencer.
  always_comb begin
    state_s   = state_r;
    step_s    = step_r;
    nblk_s    = nblk_r;
    final_m_s = final_m_r;
    blk_idx_s = blk_idx_r;
    cnt_s     = cnt_r;
    cmd_s     = cmd_r;
    h_sel_s   = h_sel_r;
    busy_s    = busy_r;
    done_s    = 1'b0;
    err_s     = err_r;

    case (state_r)
      S_IDLE, S_DONE, S_ERR: begin
        cmd_s = CMD_IDLE;
        if (start_ok_s) begin
          nblk_s    = bus.NBLK;
          final_m_s = bus.FINAL_M;
          step_s    = STEP_LOAD_H;
          blk_idx_s = BLK_ZERO;
          cnt_s     = CNT_ZERO;
          err_s     = 1'b0;
          busy_s    = 1'b1;
          state_s   = S_ISSUE;
        end else if (state_r == S_ERR) begin
          // ERR is sticky until a fresh message or reset.
          state_s = S_ERR;
        end else begin
          state_s = S_IDLE;
        end
      end

      S_ISSUE: begin
        cmd_s   = step_code(step_r, last_blk_s, final_m_r);
        // Only the very first LOAD_H of a message starts from the IV.
        h_sel_s = !((step_r == STEP_LOAD_H) && (blk_idx_r == BLK_ZERO));
        cnt_s   = CNT_ZERO;
        state_s = S_WAIT_RDY;
      end

      S_WAIT_RDY: begin
        if (bus.RDY) begin
          cmd_s   = CMD_IDLE;
          state_s = S_RELEASE;
        end else if (cnt_r == CNT_LAST) begin
          cmd_s   = CMD_IDLE;
          err_s   = 1'b1;
          busy_s  = 1'b0;
          state_s = S_ERR;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end

      S_RELEASE: begin
        // Extra idle cycle so CMD=0 is always visible to the core for at least 2 cycles.
        cnt_s   = CNT_ZERO;
        state_s = S_WAIT_CLR;
      end

      S_WAIT_CLR: begin
        if (!bus.RDY) begin
          case (step_r)
            STEP_LOAD_H: begin
              step_s  = STEP_HASH;
              state_s = S_ISSUE;
            end
            STEP_HASH: begin
              step_s  = STEP_SUM;
              state_s = S_ISSUE;
            end
            STEP_SUM: begin
              if (last_blk_s) begin
                done_s  = 1'b1;
                busy_s  = 1'b0;
                state_s = S_DONE;
              end else begin
                step_s    = STEP_LOAD_H;
                blk_idx_s = blk_idx_r + BLK_ONE;
                state_s   = S_ISSUE;
              end
            end
            default: begin
              // Corrupted step register: stop and report rather than guess.
              err_s   = 1'b1;
              busy_s  = 1'b0;
              state_s = S_ERR;
            end
          endcase
        end else if (cnt_r == CNT_LAST) begin
          err_s   = 1'b1;
          busy_s  = 1'b0;
          state_s = S_ERR;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end

      default: begin
        cmd_s   = CMD_IDLE;
        busy_s  = 1'b0;
        state_s = S_IDLE;
      end
    endcase
  end

  // State and registered-output update with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r   <= S_IDLE;
      step_r    <= STEP_LOAD_H;
      nblk_r    <= BLK_ZERO;
      final_m_r <= 1'b0;
      blk_idx_r <= BLK_ZERO;
      cnt_r     <= CNT_ZERO;
      cmd_r     <= CMD_IDLE;
      h_sel_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      step_r    <= step_s;
      nblk_r    <= nblk_s;
      final_m_r <= final_m_s;
      blk_idx_r <= blk_idx_s;
      cnt_r     <= cnt_s;
      cmd_r     <= cmd_s;
      h_sel_r   <= h_sel_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      err_r     <= err_s;
    end
  end

  assign bus.CMD     = cmd_r;
  assign bus.H_SEL   = h_sel_r;
  assign bus.BLK_IDX = blk_idx_r;
  assign bus.BUSY    = busy_r;
  assign bus.DONE    = done_r;
  assign bus.ERR     = err_r;

endmodule

// File: tb/tb_sha_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sha_cmd_sequencer
// Self-checking bench: a behavioural core model answers commands with RDY,
// a monitor records every issued command, and the main sequence compares the
// recorded commands against the list expected for NBLK/FINAL_M.
// ---------------------------------------------------------------------------
module tb_sha_cmd_sequencer;

  localparam int MAX_BLK     = 4;
  localparam int TIMEOUT_CYC = 255;

  logic CLK;
  logic RST_N;

  sha_cmd_sequencer_if #(.MAX_BLK(MAX_BLK)) bus ();

  sha_cmd_sequencer #(.MAX_BLK(MAX_BLK), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Recorded/expected command entries: {CMD[7:0], H_SEL, BLK_IDX[2:0]}.
  logic [11:0] obs_q[$];
  logic [11:0] exp_q[$];
  int          gap_viol = 0;
  int          done_cnt = 0;

  // Core model knobs.
  bit core_hang = 1'b0;
  bit core_rand = 1'b0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Behavioural core: RDY rises some cycles after a command, falls after CMD returns to 0.
  initial begin
    int core_wait;
    int cur_delay;
    bus.RDY   = 1'b0;
    core_wait = 0;
    cur_delay = 9;
    forever begin
      @(negedge CLK);
      if (bus.CMD !== 8'd0 && !$isunknown(bus.CMD)) begin
        if (!bus.RDY) begin
          if (core_wait == 0) begin
            if (core_rand) cur_delay = $urandom_range(1, 40);
            else           cur_delay = (bus.CMD == 8'd20) ? 65 : 9;
          end
          core_wait++;
          if (!(core_hang && bus.CMD == 8'd20) && core_wait >= cur_delay) bus.RDY = 1'b1;
        end
      end else begin
        core_wait = 0;
        if (bus.RDY && (!core_rand || $urandom_range(0, 1) == 1)) bus.RDY = 1'b0;
      end
    end
  end

  // Monitor: logs each new command, idle gaps between commands and DONE pulses.
  initial begin
    logic [7:0] prev_cmd;
    int         zero_run;
    prev_cmd = 8'd0;
    zero_run = 100;
    forever begin
      @(negedge CLK);
      if (bus.CMD !== 8'd0 && !$isunknown(bus.CMD) && bus.CMD !== prev_cmd) begin
        if (zero_run < 2) gap_viol++;
        obs_q.push_back({bus.CMD, bus.H_SEL, bus.BLK_IDX});
      end
      if (bus.CMD === 8'd0) zero_run++;
      else                  zero_run = 0;
      if (bus.DONE === 1'b1) done_cnt++;
      prev_cmd = bus.CMD;
    end
  end

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_tests++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Reference: each block is LOAD_H, HASH, SUM; only block 0's LOAD_H uses the IV.
  task automatic add_exp(input int nblk, input bit fm);
    for (int b = 0; b < nblk; b++) begin
      exp_q.push_back({8'd10, (b == 0) ? 1'b0 : 1'b1, 3'(b)});
      exp_q.push_back({8'd20, 1'b1, 3'(b)});
      exp_q.push_back({((b == nblk - 1) && fm) ? 8'd40 : 8'd30, 1'b1, 3'(b)});
    end
  endtask

  task automatic check_seq(input string tag);
    chk({tag, "_ncmd"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s_cmd%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
    end
    chk({tag, "_gap"}, gap_viol, 0);
  endtask

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    while (bus.DONE !== 1'b1 && t < 5000) begin
      @(negedge CLK);
      t++;
    end
    chk({tag, "_done_seen"}, 32'(bus.DONE), 32'd1);
    chk({tag, "_busy_at_done"}, 32'(bus.BUSY), 32'd0);
    @(negedge CLK);
    chk({tag, "_done_pulse"}, 32'(bus.DONE), 32'd0);
    chk({tag, "_busy_after"}, 32'(bus.BUSY), 32'd0);
    chk({tag, "_err"}, 32'(bus.ERR), 32'd0);
  endtask

  task automatic wait_cmd(input logic [7:0] code, input string tag);
    int t;
    t = 0;
    while (bus.CMD !== code && t < 2000) begin
      @(negedge CLK);
      t++;
    end
    chk({tag, "_reach_cmd"}, 32'(bus.CMD), 32'(code));
  endtask

  task automatic run_msg(input int nblk, input bit fm, input string tag);
    int d0;
    obs_q.delete();
    exp_q.delete();
    add_exp(nblk, fm);
    d0 = done_cnt;
    bus.NBLK    = 3'(nblk);
    bus.FINAL_M = fm;
    bus.START   = 1'b1;
    @(negedge CLK);
    bus.START   = 1'b0;
    // Changes while busy must not matter.
    bus.NBLK    = 3'($urandom_range(0, 7));
    bus.FINAL_M = ~fm;
    chk({tag, "_busy"}, 32'(bus.BUSY), 32'd1);
    wait_done(tag);
    chk({tag, "_ndone"}, done_cnt - d0, 1);
    check_seq(tag);
  endtask

  initial begin
    int n_tmo;
    RST_N       = 1'b0;
    bus.START   = 1'b0;
    bus.NBLK    = 3'd0;
    bus.FINAL_M = 1'b0;
    repeat (3) @(negedge CLK);

    // Reset state.
    chk("rst_cmd",   32'(bus.CMD),     32'd0);
    chk("rst_hsel",  32'(bus.H_SEL),   32'd0);
    chk("rst_idx",   32'(bus.BLK_IDX), 32'd0);
    chk("rst_busy",  32'(bus.BUSY),    32'd0);
    chk("rst_done",  32'(bus.DONE),    32'd0);
    chk("rst_err",   32'(bus.ERR),     32'd0);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    // Directed single- and two-block messages with fixed core latencies.
    run_msg(1, 1'b0, "single");
    run_msg(2, 1'b1, "two_fm");

    // Randomized messages with randomized core latencies.
    core_rand = 1'b1;
    for (int k = 0; k < 6; k++) begin
      run_msg($urandom_range(1, MAX_BLK), 1'($urandom_range(0, 1)), $sformatf("rand%0d", k));
    end
    core_rand = 1'b0;

    // Timeout: core never answers HASH.
    core_hang = 1'b1;
    obs_q.delete();
    bus.NBLK  = 3'd1;
    bus.START = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
    wait_cmd(8'd20, "tmo");
    n_tmo = 0;
    while (bus.ERR !== 1'b1 && n_tmo < 1000) begin
      @(negedge CLK);
      n_tmo++;
    end
    chk("tmo_cycles", n_tmo, TIMEOUT_CYC);
    chk("tmo_cmd",  32'(bus.CMD),  32'd0);
    chk("tmo_busy", 32'(bus.BUSY), 32'd0);
    chk("tmo_done", 32'(bus.DONE), 32'd0);
    repeat (5) @(negedge CLK);
    chk("tmo_sticky", 32'(bus.ERR), 32'd1);

    // Restart from the error state.
    core_hang = 1'b0;
    obs_q.delete();
    exp_q.delete();
    add_exp(1, 1'b0);
    bus.FINAL_M = 1'b0;
    bus.START   = 1'b1;
    @(negedge CLK);
    bus.START   = 1'b0;
    chk("restart_err",  32'(bus.ERR),  32'd0);
    chk("restart_busy", 32'(bus.BUSY), 32'd1);
    @(negedge CLK);
    chk("restart_cmd",  32'(bus.CMD),  32'd10);
    wait_done("restart");
    check_seq("restart");

    // Reset in the middle of HASH.
    bus.NBLK  = 3'd3;
    bus.START = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
    wait_cmd(8'd20, "midrst");
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    chk("midrst_cmd",  32'(bus.CMD),     32'd0);
    chk("midrst_busy", 32'(bus.BUSY),    32'd0);
    chk("midrst_idx",  32'(bus.BLK_IDX), 32'd0);
    chk("midrst_err",  32'(bus.ERR),     32'd0);
    repeat (10) @(negedge CLK);
    chk("midrst_idle", 32'(bus.CMD),     32'd0);

    // Illegal block counts are ignored.
    obs_q.delete();
    bus.NBLK  = 3'd0;
    bus.START = 1'b1;
    @(negedge CLK);
    bus.NBLK  = 3'(MAX_BLK + 1);
    @(negedge CLK);
    bus.START = 1'b0;
    repeat (20) @(negedge CLK);
    chk("illegal_busy", 32'(bus.BUSY), 32'd0);
    chk("illegal_ncmd", obs_q.size(), 0);

    // START re-pulsed while busy is ignored.
    obs_q.delete();
    exp_q.delete();
    add_exp(2, 1'b0);
    bus.NBLK    = 3'd2;
    bus.FINAL_M = 1'b0;
    bus.START   = 1'b1;
    @(negedge CLK);
    bus.START   = 1'b0;
    for (int p = 0; p < 4; p++) begin
      repeat (30) @(negedge CLK);
      bus.NBLK    = 3'd4;
      bus.FINAL_M = 1'b1;
      bus.START   = 1'b1;
      @(negedge CLK);
      bus.START   = 1'b0;
    end
    wait_done("overlap");
    check_seq("overlap");

    // START held through the DONE cycle starts the next message immediately.
    obs_q.delete();
    exp_q.delete();
    add_exp(1, 1'b0);
    add_exp(2, 1'b1);
    bus.NBLK    = 3'd1;
    bus.FINAL_M = 1'b0;
    bus.START   = 1'b1;
    @(negedge CLK);
    bus.START   = 1'b0;
    wait_cmd(8'd30, "b2b");
    bus.NBLK    = 3'd2;
    bus.FINAL_M = 1'b1;
    bus.START   = 1'b1;
    begin
      int t;
      t = 0;
      while (bus.DONE !== 1'b1 && t < 2000) begin
        @(negedge CLK);
        t++;
      end
    end
    chk("b2b_first_done", 32'(bus.DONE), 32'd1);
    @(negedge CLK);
    bus.START = 1'b0;
    chk("b2b_busy",   32'(bus.BUSY), 32'd1);
    chk("b2b_nodone", 32'(bus.DONE), 32'd0);
    @(negedge CLK);
    chk("b2b_cmd",  32'(bus.CMD),   32'd10);
    chk("b2b_hsel", 32'(bus.H_SEL), 32'd0);
    wait_done("b2b");
    check_seq("b2b");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
